// File: rtl/decimator4x_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : decimator4x_if                                            |
// | Purpose  : Sample-stream bundle between the 192 kHz and 48 kHz sides  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface decimator4x_if;
  logic               clken4x;
  logic               clkenout;
  logic signed [17:0] xkin;
  logic signed [17:0] ykout;
  logic               ykvalid;
  logic               phaseerr;

  modport master (
    output clken4x,
    output clkenout,
    output xkin,
    input  ykout,
    input  ykvalid,
    input  phaseerr
  );

  modport slave (
    input  clken4x,
    input  clkenout,
    input  xkin,
    output ykout,
    output ykvalid,
    output phaseerr
  );
endinterface
`default_nettype wire

// File: rtl/decimator4x.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : decimator4x                                               |
// | Purpose  : 4:1 boxcar-average decimator, 18-bit signed, 4xFs -> Fs   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module decimator4x (
  input  wire logic     clock,
  input  wire logic     reset,
  decimator4x_if.slave  bus
);

  localparam logic [2:0] c_WIN_LEN = 3'd4;
  localparam logic [2:0] c_CNT_MAX = 3'd7;

  logic signed [17:0] r_h0;
  logic signed [17:0] r_h1;
  logic signed [17:0] r_h2;
  logic signed [17:0] r_h3;
  logic signed [19:0] r_sum;
  logic signed [17:0] r_y;
  logic               r_valid;
  logic               r_err;
  logic               r_seen;
  logic [2:0]         r_cnt;

  logic signed [19:0] w_xk_ext;
  logic signed [19:0] w_h3_ext;
  logic signed [19:0] w_sum;
  logic signed [17:0] w_y;
  logic               w_misaligned;
  logic [2:0]         w_cnt_next;

  assign w_xk_ext = {{2{bus.xkin[17]}}, bus.xkin};
  assign w_h3_ext = {{2{r_h3[17]}}, r_h3};

  // Running sum of the history as it will stand after this edge's shift.
  always_comb begin
    w_sum = r_sum;
    if (bus.clken4x) begin
      w_sum = r_sum + w_xk_ext - w_h3_ext;
    end
  end

  // (s + 2) >>> 2 == floor(s / 4) + s[1]; the +1 can never overflow since
  // the sum only reaches 4*131071 with s[1] clear.
  assign w_y = w_sum[19:2] + {17'd0, w_sum[1]};

  assign w_misaligned = r_seen && (r_cnt != c_WIN_LEN);

  always_comb begin
    w_cnt_next = r_cnt;
    if (bus.clkenout) begin
      w_cnt_next = bus.clken4x ? 3'd1 : 3'd0;
    end else if (bus.clken4x && (r_cnt != c_CNT_MAX)) begin
      w_cnt_next = r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_h0    <= '0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_h3    <= '0;
      r_sum   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (bus.clken4x) begin
        r_h0 <= bus.xkin;
        r_h1 <= r_h0;
        r_h2 <= r_h1;
        r_h3 <= r_h2;
      end
      r_sum   <= w_sum;
      r_cnt   <= w_cnt_next;
      r_valid <= bus.clkenout;
      if (bus.clkenout) begin
        r_y    <= w_y;
        r_seen <= 1'b1;
        if (w_misaligned) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.ykout    = r_y;
  assign bus.ykvalid  = r_valid;
  assign bus.phaseerr = r_err;

endmodule
`default_nettype wire
